// File: rtl/clk_div_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : clk_div_pkg
// Purpose  : Shared types and helpers for the programmable clock divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

    // Number of high cycles in an N-cycle divided period
    function automatic int unsigned half(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : clk_div_ctrl_if
// Purpose  : Ratio-configuration handshake between CSR logic and the divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
//------------------------------------------------------------------------------
// Module   : clk_div_ctrl
// Purpose  : Divide-by-N clock-enable / divided clock generator whose ratio and
//            run/stop changes are applied only at period boundaries.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             run,
    clk_div_ctrl_if.slave         cfg,
    output logic                  clk_en,
    output logic                  clk_out,
    output logic                  busy,
    output logic [CNT_W-1:0]      div_active
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_pend;
    logic             r_clk_out;
    logic             r_cfg_err;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_div_nx;
    logic [CNT_W-1:0] w_pend_nx;
    logic [CNT_W-1:0] w_half_nx;
    logic             w_boundary;
    logic             w_xfer;
    logic             w_ratio_ok;

    assign w_boundary = (r_state != IDLE) && (r_cnt == r_div - CNT_W'(1));
    assign w_xfer     = cfg.cfg_valid && cfg.cfg_ready;
    assign w_ratio_ok = (cfg.cfg_div >= CNT_W'(MIN_DIV));

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_div_nx   = r_div;
        w_pend_nx  = r_pend;
        unique case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (w_xfer && w_ratio_ok) begin
                    w_div_nx = cfg.cfg_div;
                end
                if (run) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (w_boundary) begin
                    // A ratio arriving exactly on the boundary needs no parking
                    w_cnt_nx   = '0;
                    w_state_nx = run ? RUN : IDLE;
                    if (w_xfer && w_ratio_ok) begin
                        w_div_nx = cfg.cfg_div;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                    if (w_xfer && w_ratio_ok) begin
                        w_pend_nx  = cfg.cfg_div;
                        w_state_nx = PENDING;
                    end
                end
            end
            PENDING: begin
                if (w_boundary) begin
                    w_cnt_nx   = '0;
                    w_div_nx   = r_pend;
                    w_state_nx = run ? RUN : IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    assign w_half_nx = CNT_W'(half(32'(w_div_nx)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div     <= CNT_W'(DEFAULT_DIV);
            r_pend    <= '0;
            r_clk_out <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_div     <= w_div_nx;
            r_pend    <= w_pend_nx;
            r_clk_out <= (w_state_nx != IDLE) && (w_cnt_nx < w_half_nx);
            r_cfg_err <= w_xfer && !w_ratio_ok;
        end
    end

    assign clk_en        = w_boundary;
    assign clk_out       = r_clk_out;
    assign busy          = (r_state != IDLE);
    assign div_active    = r_div;
    assign cfg.cfg_ready = (r_state != PENDING);
    assign cfg.cfg_err   = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_clk_div_ctrl
// Purpose  : Scoreboard bench for clk_div_ctrl against a period-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_ctrl;

    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             clk_en;
    logic             clk_out;
    logic             busy;
    logic [CNT_W-1:0] div_active;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_div_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .cfg        (cfg_if.slave),
        .clk_en     (clk_en),
        .clk_out    (clk_out),
        .busy       (busy),
        .div_active (div_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        bit co;
        bit bsy;
        bit rdy;
        bit err;
        int div;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Period-level model: whether a period is in progress, position in it,
    // the ratio in force and at most one parked ratio.
    bit m_active = 0;
    int m_pos    = 0;
    int m_ratio  = DEFAULT_DIV;
    int m_pend[$];
    bit m_err    = 0;

    task automatic model_step(input bit r, input bit rn, input bit v, input int d);
        bit take, good, last;
        if (r) begin
            m_active = 0;
            m_pos    = 0;
            m_ratio  = DEFAULT_DIV;
            m_pend.delete();
            m_err    = 0;
        end else begin
            take  = v && (m_pend.size() == 0);
            good  = take && (d >= 2);
            last  = m_active && (m_pos == m_ratio - 1);
            m_err = take && (d < 2);
            if (!m_active) begin
                if (good) m_ratio = d;
                if (rn) begin
                    m_active = 1;
                    m_pos    = 0;
                end
            end else if (last) begin
                if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
                else if (good)          m_ratio = d;
                m_pos    = 0;
                m_active = rn;
            end else begin
                m_pos++;
                if (good) m_pend.push_back(d);
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.en  = m_active && (m_pos == m_ratio - 1);
        e.co  = m_active && (m_pos < m_ratio / 2);
        e.bsy = m_active;
        e.rdy = (m_pend.size() == 0);
        e.err = m_err;
        e.div = m_ratio;
        return e;
    endfunction

    task automatic cyc(input bit r, input bit rn, input bit v, input int d);
        @(negedge clk);
        rst              = r;
        run              = rn;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_div   = d[CNT_W-1:0];
        @(posedge clk);
        model_step(r, rn, v, d);
        exp_q.push_back(model_out());
    endtask

    task automatic idle_cycles(input int n, input bit rn);
        repeat (n) cyc(0, rn, 0, 0);
    endtask

    // Advance until the upcoming cycle sits at period position p
    task automatic wait_pos(input int p, input bit rn);
        for (int i = 0; i < 600; i++) begin
            if (m_active && m_pos == p) return;
            cyc(0, rn, 0, 0);
        end
        checks++;
        errors++;
        $display("FAIL wait_pos timeout actual=none required=pos %0d", p);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("clk_en",     int'(clk_en),           int'(e.en));
            chk("clk_out",    int'(clk_out),          int'(e.co));
            chk("busy",       int'(busy),             int'(e.bsy));
            chk("cfg_ready",  int'(cfg_if.cfg_ready), int'(e.rdy));
            chk("cfg_err",    int'(cfg_if.cfg_err),   int'(e.err));
            chk("div_active", int'(div_active),       e.div);
        end
    end

    initial begin
        int d;
        rst              = 1'b1;
        run              = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;

        repeat (3) cyc(1, 0, 0, 0);
        idle_cycles(8, 1);

        // Ratio 5 loaded while stopped, then started
        idle_cycles(4, 0);
        cyc(0, 0, 1, 5);
        idle_cycles(16, 1);

        // Ratio change offered at position 1 of a 4-cycle period
        cyc(0, 1, 1, 4);
        idle_cycles(10, 1);
        wait_pos(1, 1);
        cyc(0, 1, 1, 3);
        cyc(0, 1, 1, 7);
        cyc(0, 1, 1, 7);
        idle_cycles(10, 1);

        // Rejected ratios
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        idle_cycles(4, 1);

        // Stop requested mid-period at N=6
        cyc(0, 1, 1, 6);
        idle_cycles(10, 1);
        wait_pos(2, 1);
        idle_cycles(8, 0);

        // Start in the same cycle a ratio is accepted, then a short run glitch
        cyc(0, 1, 1, 5);
        wait_pos(1, 1);
        cyc(0, 0, 0, 0);
        idle_cycles(10, 1);

        // Reset while a ratio is parked
        wait_pos(1, 1);
        cyc(0, 1, 1, 9);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        idle_cycles(8, 1);

        // Largest legal ratio
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 255);
        idle_cycles(520, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(7, 0))
                0:       d = $urandom_range(1, 0);
                1:       d = ($urandom_range(3, 0) == 0) ? 255 : $urandom_range(40, 13);
                default: d = $urandom_range(12, 2);
            endcase
            cyc(($urandom_range(199, 0) == 0),
                ($urandom_range(15, 0) != 0),
                ($urandom_range(5, 0) == 0),
                d);
        end

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
